// File: rtl/gem_fiber_rx_deframer_if.sv
// Bundle of the GEM fiber receive deframer signals.
//   RX_DATA/RX_CHARISK/RX_DISPERR/RX_NOTINTABLE : GTX decoded word stream (80 MHz)
//   CLR_CNT        : synchronous clear of both error counters
//   GEM_DATA       : 56-bit reassembled payload
//   GEM_OVERFLOW   : delivered frame carried the FC separator
//   BX_PHASE       : last non-FC separator index (BC=0, F7=1, FB=2, FD=3)
//   DATA_VALID     : one-cycle strobe per delivered frame
//   LOCKED         : deframer is in the LOCKED state
//   LINK_IDLE      : last received word was the idle pattern
//   FRM_ERR_CNT    : saturating bad-frame count
//   SEQ_ERR_CNT    : saturating bunch-sequence error count
// master drives the receive stream, slave is the deframer.
interface gem_fiber_rx_deframer_if;
  logic [31:0] RX_DATA;
  logic [3:0]  RX_CHARISK;
  logic [3:0]  RX_DISPERR;
  logic [3:0]  RX_NOTINTABLE;
  logic        CLR_CNT;
  logic [55:0] GEM_DATA;
  logic        GEM_OVERFLOW;
  logic [1:0]  BX_PHASE;
  logic        DATA_VALID;
  logic        LOCKED;
  logic        LINK_IDLE;
  logic [15:0] FRM_ERR_CNT;
  logic [15:0] SEQ_ERR_CNT;

  modport master (
    output RX_DATA, RX_CHARISK, RX_DISPERR, RX_NOTINTABLE, CLR_CNT,
    input  GEM_DATA, GEM_OVERFLOW, BX_PHASE, DATA_VALID, LOCKED, LINK_IDLE,
           FRM_ERR_CNT, SEQ_ERR_CNT
  );

  modport slave (
    input  RX_DATA, RX_CHARISK, RX_DISPERR, RX_NOTINTABLE, CLR_CNT,
    output GEM_DATA, GEM_OVERFLOW, BX_PHASE, DATA_VALID, LOCKED, LINK_IDLE,
           FRM_ERR_CNT, SEQ_ERR_CNT
  );
endinterface

// File: rtl/gem_fiber_rx_deframer.sv
// Receive-side deframer for the GEM trigger fiber link.
// Consumes two 32-bit words per bunch crossing (A-word with no K flags, then a
// B-word whose byte 0 is a separator K-code), aligns on the separator,
// reassembles {A[31:0], B[31:8]} into a 56-bit payload, checks the
// BC->F7->FB->FD bunch order and keeps saturating error counters.
// Ports:
//   TRG_CLK80  : 80 MHz RX user clock, rising edge
//   TRG_RST_N  : asynchronous active-low reset
//   bus        : gem_fiber_rx_deframer_if.slave (receive stream in, status out)
module gem_fiber_rx_deframer #(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 3
) (
  input  logic                          TRG_CLK80,
  input  logic                          TRG_RST_N,
  gem_fiber_rx_deframer_if.slave        bus
);

  localparam logic [7:0]  SEP_BC   = 8'hBC;
  localparam logic [7:0]  SEP_F7   = 8'hF7;
  localparam logic [7:0]  SEP_FB   = 8'hFB;
  localparam logic [7:0]  SEP_FD   = 8'hFD;
  localparam logic [7:0]  SEP_FC   = 8'hFC;
  localparam logic [31:0] IDLE_PAT = 32'h50BC50BC;
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Separator byte to bunch index; only called on non-FC separators.
  function automatic logic [1:0] sep_idx(input logic [7:0] b);
    case (b)
      SEP_BC:  return 2'd0;
      SEP_F7:  return 2'd1;
      SEP_FB:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic [1:0]  exp_q, exp_d;
  logic        deliver, frm_inc, seq_inc;

  logic [31:0] a_word_p0;
  logic        a_ok_p0;

  logic [55:0] gem_data_p1;
  logic        ovf_p1;
  logic [1:0]  bx_p1;
  logic        vld_p1;
  logic        link_idle_p1;
  logic [15:0] frm_err_cnt_q;
  logic [15:0] seq_err_cnt_q;

  logic [7:0]  byte0;
  logic        is_fc, is_sep, is_a, is_b, is_idle, clean, frame_good;
  logic [1:0]  rx_idx;

  assign byte0      = bus.RX_DATA[7:0];
  assign is_fc      = (byte0 == SEP_FC);
  assign is_sep     = (byte0 == SEP_BC) || (byte0 == SEP_F7) || (byte0 == SEP_FB) ||
                      (byte0 == SEP_FD) || is_fc;
  assign is_a       = (bus.RX_CHARISK == 4'b0000);
  assign is_b       = (bus.RX_CHARISK == 4'b0001) && is_sep;
  assign is_idle    = (bus.RX_DATA == IDLE_PAT) && (bus.RX_CHARISK == 4'b0101);
  assign clean      = ~|{bus.RX_DISPERR, bus.RX_NOTINTABLE};
  assign frame_good = a_ok_p0 && is_b && clean;
  assign rx_idx     = sep_idx(byte0);

  // Next-state: frames are only judged on phase 1, idle overrides everything.
  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    good_d  = good_q;
    bad_d   = bad_q;
    exp_d   = exp_q;
    deliver = 1'b0;
    frm_inc = 1'b0;
    seq_inc = 1'b0;
    if (is_idle) begin
      state_d = ST_HUNT;
      phase_d = 1'b0;
      good_d  = 4'd0;
      bad_d   = 4'd0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          phase_d = 1'b0;
          good_d  = 4'd0;
          bad_d   = 4'd0;
          if (is_b && clean) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (phase_q) begin
            if (frame_good) begin
              good_d = good_q + 4'd1;
              // Track the bunch order here so LOCKED starts with a seeded expectation.
              exp_d  = is_fc ? exp_q + 2'd1 : rx_idx + 2'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_d = ST_LOCKED;
                bad_d   = 4'd0;
              end
            end else begin
              state_d = ST_HUNT;
              phase_d = 1'b0;
              good_d  = 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (phase_q) begin
            if (frame_good) begin
              deliver = 1'b1;
              bad_d   = 4'd0;
              if (is_fc) begin
                exp_d = exp_q + 2'd1;
              end else begin
                seq_inc = (rx_idx != exp_q);
                exp_d   = rx_idx + 2'd1;
              end
            end else begin
              frm_inc = 1'b1;
              if (bad_q + 4'd1 == UNLOCK_N) begin
                state_d = ST_HUNT;
                phase_d = 1'b0;
                good_d  = 4'd0;
                bad_d   = 4'd0;
              end else begin
                bad_d = bad_q + 4'd1;
              end
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          phase_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      state_q <= ST_HUNT;
      phase_q <= 1'b0;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      exp_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      exp_q   <= exp_d;
    end
  end

  // Stage p0: hold the A-word of the current frame until its B-word arrives.
  always_ff @(posedge TRG_CLK80) begin
    if (!phase_q) a_word_p0 <= bus.RX_DATA;
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      a_ok_p0 <= 1'b0;
    end else if (!phase_q) begin
      a_ok_p0 <= is_a && clean;
    end
  end

  // Stage p1: registered payload, strobe and status, one cycle after the B-word.
  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      gem_data_p1   <= 56'd0;
      ovf_p1        <= 1'b0;
      bx_p1         <= 2'd0;
      vld_p1        <= 1'b0;
      link_idle_p1  <= 1'b0;
      frm_err_cnt_q <= 16'd0;
      seq_err_cnt_q <= 16'd0;
    end else begin
      vld_p1       <= deliver;
      link_idle_p1 <= is_idle;
      if (deliver) begin
        gem_data_p1 <= {a_word_p0, bus.RX_DATA[31:8]};
        ovf_p1      <= is_fc;
        if (!is_fc) bx_p1 <= rx_idx;
      end
      if (bus.CLR_CNT)  frm_err_cnt_q <= 16'd0;
      else if (frm_inc) frm_err_cnt_q <= sat_inc(frm_err_cnt_q);
      if (bus.CLR_CNT)  seq_err_cnt_q <= 16'd0;
      else if (seq_inc) seq_err_cnt_q <= sat_inc(seq_err_cnt_q);
    end
  end

  assign bus.GEM_DATA     = gem_data_p1;
  assign bus.GEM_OVERFLOW = ovf_p1;
  assign bus.BX_PHASE     = bx_p1;
  assign bus.DATA_VALID   = vld_p1;
  assign bus.LOCKED       = (state_q == ST_LOCKED);
  assign bus.LINK_IDLE    = link_idle_p1;
  assign bus.FRM_ERR_CNT  = frm_err_cnt_q;
  assign bus.SEQ_ERR_CNT  = seq_err_cnt_q;

endmodule
